// File: rtl/ctrl_unit.sv
// ctrl_unit: RV32 instruction decode and control, with a one-cycle kill of the
// instruction fetched behind a taken jump or branch.
module ctrl_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       b,
    output logic [2:0] imm_type,
    output logic [3:0] alu_op,
    output logic       alu_src_b,
    output logic       reg_we,
    output logic [1:0] rd_src,
    output logic       mem_we,
    output logic       mem_re,
    output logic [1:0] mem_size,
    output logic       mem_unsigned,
    output logic [1:0] pc_src,
    output logic       flush
);
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_U    = 3'b001;
    localparam logic [2:0] IMM_J    = 3'b010;
    localparam logic [2:0] IMM_S    = 3'b011;
    localparam logic [2:0] IMM_I    = 3'b100;
    localparam logic [2:0] IMM_B    = 3'b101;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b0110;
    localparam logic [3:0] ALU_EQ  = 4'b0111;
    localparam logic [3:0] ALU_GE  = 4'b1000;
    localparam logic [3:0] ALU_LTU = 4'b1001;

    logic       alt_f7;
    logic [3:0] arith_op;
    logic [3:0] br_op;
    logic       br_ok;
    logic       reg_we_raw;
    logic       mem_we_raw;
    logic       mem_re_raw;
    logic [1:0] pc_src_raw;
    logic       flush_q;
    logic       flush_d;

    assign alt_f7 = (func7 == 7'b0100000);

    // Shared register/immediate ALU selection; SUB only exists for the register form.
    always_comb begin
        arith_op = ALU_ADD;
        case (func3)
            3'b000: arith_op = (opcode == OP_OP && alt_f7) ? ALU_SUB : ALU_ADD;
            3'b010: arith_op = ALU_SLT;
            3'b100: arith_op = ALU_XOR;
            3'b001: arith_op = ALU_SLL;
            3'b101: arith_op = alt_f7 ? ALU_SRA : ALU_SRL;
            default: arith_op = ALU_ADD;
        endcase
    end

    always_comb begin
        br_op = ALU_EQ;
        br_ok = 1'b1;
        case (func3)
            3'b000: br_op = ALU_EQ;
            3'b101: br_op = ALU_GE;
            3'b110: br_op = ALU_LTU;
            default: br_ok = 1'b0;
        endcase
    end

    always_comb begin
        imm_type   = IMM_NONE;
        alu_op     = ALU_ADD;
        alu_src_b  = 1'b0;
        reg_we_raw = 1'b0;
        rd_src     = 2'b00;
        mem_we_raw = 1'b0;
        mem_re_raw = 1'b0;
        pc_src_raw = 2'b00;
        case (opcode)
            OP_LUI: begin
                imm_type   = IMM_U;
                rd_src     = 2'b11;
                reg_we_raw = 1'b1;
            end
            OP_OPIMM: begin
                imm_type   = IMM_I;
                alu_op     = arith_op;
                alu_src_b  = 1'b1;
                reg_we_raw = 1'b1;
            end
            OP_OP: begin
                alu_op     = arith_op;
                reg_we_raw = 1'b1;
            end
            OP_LOAD: begin
                imm_type   = IMM_I;
                alu_src_b  = 1'b1;
                mem_re_raw = 1'b1;
                reg_we_raw = 1'b1;
                rd_src     = 2'b01;
            end
            OP_STORE: begin
                imm_type   = IMM_S;
                alu_src_b  = 1'b1;
                mem_we_raw = 1'b1;
            end
            OP_JAL: begin
                imm_type   = IMM_J;
                pc_src_raw = 2'b01;
                reg_we_raw = 1'b1;
                rd_src     = 2'b10;
            end
            OP_JALR: begin
                imm_type   = IMM_I;
                alu_src_b  = 1'b1;
                pc_src_raw = 2'b10;
                reg_we_raw = 1'b1;
                rd_src     = 2'b10;
            end
            OP_BRANCH: begin
                imm_type   = IMM_B;
                alu_op     = br_op;
                pc_src_raw = (br_ok && b) ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
    end

    assign mem_size     = func3[1:0];
    assign mem_unsigned = (opcode == OP_LOAD) ? func3[2] : 1'b0;

    // A killed slot must not write state nor redirect, so it can never re-arm flush.
    assign reg_we = reg_we_raw & ~flush_q;
    assign mem_we = mem_we_raw & ~flush_q;
    assign mem_re = mem_re_raw & ~flush_q;
    assign pc_src = flush_q ? 2'b00 : pc_src_raw;
    assign flush  = flush_q;

    assign flush_d = (pc_src != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flush_q <= 1'b0;
        else     flush_q <= flush_d;
    end
endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: scoreboard bench for ctrl_unit; expected decode vectors are
// queued as stimulus is applied and compared once the outputs settle.
module tb_ctrl_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       b;
    logic [2:0] imm_type;
    logic [3:0] alu_op;
    logic       alu_src_b;
    logic       reg_we;
    logic [1:0] rd_src;
    logic       mem_we;
    logic       mem_re;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic [1:0] pc_src;
    logic       flush;

    int checks = 0;
    int errors = 0;
    logic        m_flush = 1'b0;
    logic [18:0] sb_q[$];

    ctrl_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .b(b),
        .imm_type(imm_type), .alu_op(alu_op), .alu_src_b(alu_src_b), .reg_we(reg_we),
        .rd_src(rd_src), .mem_we(mem_we), .mem_re(mem_re), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .pc_src(pc_src), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Packed as {imm3, alu4, srcb, reg_we, rd2, mem_we, mem_re, size2, uns, pc2, flush}.
    function automatic logic [18:0] model(input logic [4:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic bb, input logic fl);
        logic [2:0] imm = 3'd0;
        logic [3:0] alu = 4'd0;
        logic srcb = 0, we = 0, mw = 0, mr = 0;
        logic [1:0] rd = 2'd0, pc = 2'd0;
        logic alt = (f7 == 7'h20);
        case (op)
            5'b01101: begin imm = 3'd1; rd = 2'd3; we = 1; end
            5'b00100, 5'b01100: begin
                imm  = (op == 5'b00100) ? 3'd4 : 3'd0;
                srcb = (op == 5'b00100);
                we   = 1;
                case (f3)
                    3'b000: alu = (op == 5'b01100 && alt) ? 4'd1 : 4'd0;
                    3'b010: alu = 4'd2;
                    3'b100: alu = 4'd3;
                    3'b001: alu = 4'd4;
                    3'b101: alu = alt ? 4'd6 : 4'd5;
                    default: alu = 4'd0;
                endcase
            end
            5'b00000: begin imm = 3'd4; srcb = 1; mr = 1; we = 1; rd = 2'd1; end
            5'b01000: begin imm = 3'd3; srcb = 1; mw = 1; end
            5'b11011: begin imm = 3'd2; pc = 2'd1; we = 1; rd = 2'd2; end
            5'b11001: begin imm = 3'd4; srcb = 1; pc = 2'd2; we = 1; rd = 2'd2; end
            5'b11000: begin
                imm = 3'd5;
                alu = (f3 == 3'b101) ? 4'd8 : (f3 == 3'b110) ? 4'd9 : 4'd7;
                pc  = (bb && (f3 == 3'b000 || f3 == 3'b101 || f3 == 3'b110)) ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
        if (fl) begin we = 0; mw = 0; mr = 0; pc = 2'd0; end
        return {imm, alu, srcb, we, rd, mw, mr, f3[1:0], (op == 5'b00000) ? f3[2] : 1'b0, pc, fl};
    endfunction

    task automatic step(input string tag, input logic [4:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic bb);
        logic [18:0] exp;
        logic [18:0] obs;
        @(negedge clk);
        opcode = op; func3 = f3; func7 = f7; b = bb;
        sb_q.push_back(model(op, f3, f7, bb, m_flush));
        #2;
        obs = {imm_type, alu_op, alu_src_b, reg_we, rd_src, mem_we, mem_re, mem_size,
               mem_unsigned, pc_src, flush};
        exp = sb_q.pop_front();
        check(tag, {13'd0, obs}, {13'd0, exp});
        m_flush = (exp[2:1] != 2'b00);
    endtask

    initial begin
        logic [4:0] ops [9];
        ops = '{5'b00000, 5'b00100, 5'b01000, 5'b01100, 5'b01101,
                5'b11000, 5'b11001, 5'b11011, 5'b11111};
        rst = 1'b1; opcode = 5'b01101; func3 = 3'd0; func7 = 7'd0; b = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset_flush", {31'd0, flush}, 32'd0);
        @(negedge clk) rst = 1'b0;
        step("lui",       5'b01101, 3'b000, 7'h00, 1'b0);
        step("opimm_add", 5'b00100, 3'b000, 7'h20, 1'b0);
        step("opimm_sra", 5'b00100, 3'b101, 7'h20, 1'b0);
        step("store",     5'b01000, 3'b010, 7'h00, 1'b0);
        step("op_sub",    5'b01100, 3'b000, 7'h20, 1'b0);
        step("op_add",    5'b01100, 3'b000, 7'h00, 1'b0);
        step("op_sra",    5'b01100, 3'b101, 7'h20, 1'b0);
        step("op_srl",    5'b01100, 3'b101, 7'h00, 1'b0);
        step("op_slt",    5'b01100, 3'b010, 7'h00, 1'b0);
        step("load_hu",   5'b00000, 3'b101, 7'h00, 1'b0);
        step("bge_taken", 5'b11000, 3'b101, 7'h00, 1'b1);
        step("kill_load", 5'b00000, 3'b010, 7'h00, 1'b0);
        step("kill_store_after", 5'b01000, 3'b000, 7'h00, 1'b0);
        step("bge_not",   5'b11000, 3'b101, 7'h00, 1'b0);
        step("after_bnt", 5'b00100, 3'b100, 7'h00, 1'b0);
        step("bltu_taken", 5'b11000, 3'b110, 7'h00, 1'b1);
        step("kill_bltu", 5'b11000, 3'b110, 7'h00, 1'b1);
        step("bad_f3_br", 5'b11000, 3'b001, 7'h00, 1'b1);
        step("jal",       5'b11011, 3'b000, 7'h00, 1'b0);
        step("jal_killed", 5'b11011, 3'b000, 7'h00, 1'b0);
        step("post_kill", 5'b01101, 3'b000, 7'h00, 1'b0);
        step("jalr",      5'b11001, 3'b000, 7'h00, 1'b0);
        step("kill_jalr", 5'b11001, 3'b000, 7'h00, 1'b0);
        step("jal_rst",   5'b11011, 3'b000, 7'h00, 1'b0);
        @(posedge clk);
        #2 check("flush_set", {31'd0, flush}, 32'd1);
        rst = 1'b1;
        #1 check("async_rst", {31'd0, flush}, 32'd0);
        m_flush = 1'b0;
        opcode = 5'b11111;
        @(negedge clk) rst = 1'b0;
        step("undef",     5'b11111, 3'b111, 7'h7f, 1'b1);
        for (int i = 0; i < 60; i++)
            step("random", ops[$urandom_range(8)], 3'($urandom), ($urandom_range(1) != 0) ? 7'h20 : 7'h00,
                 1'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctrl_unit.md
# ctrl_unit

Instruction-decode and control block of the single-issue RV32 core (`ctrl_unit`, the `ctrl` instance in the core). It takes the 5-bit major opcode (instruction bits [6:2]), func3, func7 and the ALU branch-condition flag, and drives immediate-format selection, ALU operation, operand/writeback muxes, data-memory strobes and next-PC selection. All decode is combinational. One registered bit kills the instruction fetched behind a taken control transfer.

## Interface
- No parameters.
- `clk` in 1: core clock, rising edge.
- `rst` in 1: reset; one clock; reset is asynchronous and active-high.
- `opcode` in 5: instruction bits [6:2].
- `func3` in 3: instruction bits [14:12].
- `func7` in 7: instruction bits [31:25].
- `b` in 1: ALU compare result for the current branch; 1 = condition true.
- `imm_type` out 3: 000 none, 001 IMM_U, 010 IMM_J, 011 IMM_S, 100 IMM_I, 101 IMM_B.
- `alu_op` out 4: 0000 ADD, 0001 SUB, 0010 SLT, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SRA, 0111 EQ, 1000 GE, 1001 LTU.
- `alu_src_b` out 1: 1 = immediate, 0 = rs2.
- `reg_we` out 1: register-file write enable.
- `rd_src` out 2: 00 ALU, 01 load data, 10 PC+4, 11 immediate.
- `mem_we`, `mem_re` out 1 each: data-memory store / load strobes.
- `mem_size` out 2: 00 byte, 01 half, 10 word (func3[1:0]).
- `mem_unsigned` out 1: func3[2] for loads, 0 otherwise.
- `pc_src` out 2: 00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1.
- `flush` out 1: current instruction is killed.

## Operation
- Opcode decode (opcode values binary):
  - LUI 01101: imm_type U, rd_src 11, reg_we 1.
  - OP_IMM 00100: imm_type I, alu_src_b 1, reg_we 1, rd_src 00; alu_op from func3 (000 ADD, 010 SLT, 100 XOR, 001 SLL, 101 SRL/SRA by func7).
  - OP 01100: imm_type 000, alu_src_b 0, reg_we 1, rd_src 00; func3 000 → SUB if func7=0100000 else ADD; 101 → SRA if func7=0100000 else SRL; others as OP_IMM.
  - LOAD 00000: imm_type I, alu_src_b 1, alu_op ADD, mem_re 1, reg_we 1, rd_src 01.
  - STORE 01000: imm_type S, alu_src_b 1, alu_op ADD, mem_we 1, reg_we 0.
  - JAL 11011: imm_type J, pc_src 01, reg_we 1, rd_src 10.
  - JALR 11001: imm_type I, alu_src_b 1, alu_op ADD, pc_src 10, reg_we 1, rd_src 10.
  - BRANCH 11000: imm_type B, alu_src_b 0, reg_we 0; func3 000 → EQ, 101 → GE, 110 → LTU, other func3 → EQ with pc_src forced 00; pc_src 01 when b=1 else 00.
- Any other opcode: all enables 0, imm_type 000, alu_op ADD, pc_src 00, rd_src 00.
- mem_size/mem_unsigned valid only with mem_re/mem_we; driven from func3 regardless.
- Kill: while `flush`=1 outputs reg_we, mem_we, mem_re forced 0 and pc_src forced 00; other outputs still decode.

## Timing
- Decode outputs combinational from inputs and `flush`; zero latency.
- `flush` register: next = (pc_src≠00) evaluated with the kill applied, so a killed instruction never produces another flush; flush lasts exactly one cycle per taken transfer.
- Reset: `flush` cleared to 0 asynchronously; all outputs then purely decoded from inputs. Reset mid-transfer drops the pending flush.
- `b` sampled combinationally in the same cycle as the branch.

## Test plan
- rst=1 then release, opcode=LUI → imm_type 001, reg_we 1, rd_src 11, flush 0.
- opcode=OP_IMM func3 000 → imm_type 100, alu_src_b 1, alu_op 0000; opcode=STORE → imm_type 011, mem_we 1, reg_we 0.
- OP func3 000 func7 0100000 → alu_op 0001; OP func3 101 func7 0100000 → 0110, func7 0 → 0101.
- BRANCH func3 101 b=1 → alu_op 1000, pc_src 01, flush 1 next cycle; with any opcode then reg_we/mem_we 0; b=0 → pc_src 00, no flush.
- JAL → pc_src 01, rd_src 10, flush next cycle; JAL again during flush → pc_src 00, flush returns to 0.
- Assert rst asynchronously while flush=1 → flush 0 immediately, undefined opcode 11111 → all enables 0.
